i2s_tx_sequencer: RTL and testbench

//  I2S transmit controller: derives bck/lrck from the system clock, pulls one stereo sample per frame

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_bck_divider.sv | 36 +++
 rtl/i2s_tx_sequencer.sv | 139 +++++++++++++
 tb/tb_i2s_tx_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit sequencer.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_tx_state_t;

    localparam int DEF_SAMPLE_WIDTH = 24;
    localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

    typedef struct packed {
        logic [DEF_SAMPLE_WIDTH-1:0] left;
        logic [DEF_SAMPLE_WIDTH-1:0] right;
    } i2s_stereo_t;

    function automatic int frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction

endpackage

// File: rtl/i2s_bck_divider.sv
// Bit-clock generator: down-counts BCK_DIV clk per bck half-period and flags the 1->0 edge.
module i2s_bck_divider #(
    parameter int BCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bck,
    output logic fall
);
    localparam int CW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BCK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          tc;

    assign tc   = (div_cnt == '0);
    assign fall = run && tc && bck;

    // Holding the counter at RELOAD while stopped keeps bck low for a full half-period on start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= RELOAD;
            bck     <= 1'b0;
        end else if (!run) begin
            div_cnt <= RELOAD;
            bck     <= 1'b0;
        end else if (tc) begin
            div_cnt <= RELOAD;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: bck/lrck generation, one sample fetch per frame, MSB-first serialisation.
// Build option I2S_TX_UNDERRUN_HOLD_EN: an underrun frame repeats the last transferred sample.
// state | meaning
// IDLE  | outputs parked: bck=0, lrck=1, sdata=0
// RUN   | framing; a new frame (and fetch) starts at every bit_idx wrap
// DRAIN | enable dropped; finish the current frame, then stop
module i2s_tx_sequencer
    import i2s_pkg::*;
#(
    parameter int BCK_DIV      = 2,
    parameter int SLOT_BITS    = 32,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [2*SAMPLE_WIDTH-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      bck,
    output logic                      lrck,
    output logic                      sdata,
    output logic                      running,
    output logic                      frame_start,
    output logic                      underrun,
    output logic [15:0]               underrun_count
);
    localparam int FRAME_BITS = frame_bits(SLOT_BITS);
    localparam int IW         = $clog2(FRAME_BITS);
    localparam logic [IW-1:0] LAST_BIT = IW'(FRAME_BITS - 1);
    localparam logic [IW-1:0] HALF     = IW'(SLOT_BITS);
    localparam logic [IW-1:0] L_FIRST  = IW'(1);
    localparam logic [IW-1:0] L_LAST   = IW'(SAMPLE_WIDTH);
    localparam logic [IW-1:0] R_FIRST  = IW'(SLOT_BITS + 1);
    localparam logic [IW-1:0] R_LAST   = IW'(SLOT_BITS + SAMPLE_WIDTH);

    i2s_tx_state_t state, state_next;

    logic [IW-1:0]             bit_idx, bit_next;
    logic [SAMPLE_WIDTH-1:0]   left_sr, right_sr;
    logic [2*SAMPLE_WIDTH-1:0] refill;
    logic                      fall, wrap, start_frame, stop;

    i2s_bck_divider #(.BCK_DIV(BCK_DIV)) u_bck_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (running),
        .bck     (bck),
        .fall    (fall)
    );

    assign bit_next = bit_idx + 1'b1;
    assign wrap     = fall && (bit_idx == LAST_BIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (wrap) state_next = enable ? RUN : IDLE;
                     else if (!enable) state_next = DRAIN;
            DRAIN:   if (enable) state_next = RUN;
                     else if (wrap) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running     = (state != IDLE);
        start_frame = enable && ((state == IDLE) || wrap);
        stop        = !enable && wrap;
    end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    logic [2*SAMPLE_WIDTH-1:0] hold_sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               hold_sample <= '0;
        else if (s_ready && s_valid) hold_sample <= s_data;
    end

    assign refill = hold_sample;
`else
    assign refill = '0;
`endif

    // s_ready is raised in the first clk of bit 0; the sample is needed only from bit 1 on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_idx        <= '0;
            lrck           <= 1'b1;
            sdata          <= 1'b0;
            left_sr        <= '0;
            right_sr       <= '0;
            s_ready        <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            s_ready     <= start_frame;
            frame_start <= start_frame;
            underrun    <= s_ready && !s_valid;
            if (s_ready) begin
                if (s_valid) begin
                    {left_sr, right_sr} <= s_data;
                end else begin
                    {left_sr, right_sr} <= refill;
                    if (underrun_count != UNDERRUN_MAX) underrun_count <= underrun_count + 16'd1;
                end
            end
            if (start_frame) begin
                bit_idx <= '0;
                lrck    <= 1'b0;
                sdata   <= 1'b0;
            end else if (stop) begin
                bit_idx <= '0;
                lrck    <= 1'b1;
                sdata   <= 1'b0;
            end else if (fall) begin
                bit_idx <= bit_next;
                lrck    <= (bit_next >= HALF);
                if (bit_next >= L_FIRST && bit_next <= L_LAST) begin
                    sdata   <= left_sr[SAMPLE_WIDTH-1];
                    left_sr <= left_sr << 1;
                end else if (bit_next >= R_FIRST && bit_next <= R_LAST) begin
                    sdata    <= right_sr[SAMPLE_WIDTH-1];
                    right_sr <= right_sr << 1;
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: random sample source, I2S receiver model and frame scoreboard.
module tb_i2s_tx_sequencer;
    localparam int SW        = 24;
    localparam int FRAME_CLK = 256;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [2*SW-1:0] s_data;
    logic          s_valid;
    logic          s_ready, bck, lrck, sdata, running, frame_start, underrun;
    logic [15:0]   underrun_count;

    always #5 clk = ~clk;

    i2s_tx_sequencer #(.BCK_DIV(2), .SLOT_BITS(32), .SAMPLE_WIDTH(SW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .bck            (bck),
        .lrck           (lrck),
        .sdata          (sdata),
        .running        (running),
        .frame_start    (frame_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Sample source: fresh random data every clk; the scoreboard records what was offered at each handshake.
    logic        src_on    = 1'b0;
    bit          use_fixed = 1'b0;
    int          gap_hs    = -1;
    int          hs_cnt    = 0;
    int          exp_underruns = 0;
    logic [2*SW-1:0] last_sent = '0;
    logic [2*SW-1:0] exp_q[$];

    always @(negedge clk) begin
        s_data  = use_fixed ? 48'hABCDEF_123456 : {24'($urandom), 24'($urandom)};
        s_valid = src_on && (hs_cnt != gap_hs);
        if (reset_n && s_ready) begin
            if (s_valid) begin
                exp_q.push_back(s_data);
                last_sent = s_data;
            end else begin
                exp_underruns++;
                exp_q.push_back(HOLD ? last_sent : '0);
            end
            hs_cnt++;
        end
    end

    // I2S receiver: samples on bck rising, one-bit delay after each lrck change, MSB first.
    logic        prev_bck = 1'b0;
    logic        rx_lr    = 1'b1;
    int          rx_bit   = 0;
    int          pad_errs = 0;
    logic [SW-1:0] rx_sr = '0, rx_left = '0;
    logic [2*SW-1:0] rx_q[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_bck = 1'b0;
            rx_lr    = 1'b1;
            rx_bit   = 0;
        end else begin
            if (bck && !prev_bck) begin
                if (lrck != rx_lr) begin
                    rx_lr  = lrck;
                    rx_bit = 0;
                    rx_sr  = '0;
                    if (sdata) pad_errs++;
                end else begin
                    rx_bit++;
                    if (rx_bit <= SW) begin
                        rx_sr = {rx_sr[SW-2:0], sdata};
                        if (rx_bit == SW) begin
                            if (!lrck) rx_left = rx_sr;
                            else       rx_q.push_back({rx_left, rx_sr});
                        end
                    end else if (sdata) begin
                        pad_errs++;
                    end
                end
            end
            prev_bck = bck;
        end
    end

    int cyc = 0;
    int rdy_cnt = 0;
    int ur_cnt = 0;
    int fs_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n) begin
            if (s_ready)     rdy_cnt++;
            if (underrun)    ur_cnt++;
            if (frame_start) fs_q.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_frames(input string tag);
        int n;
        check_eq({tag, "_frames"}, 64'(rx_q.size()), 64'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_sample"}, 64'(rx_q[i]), 64'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_periods(input string tag);
        for (int i = 1; i < fs_q.size(); i++)
            check_eq({tag, "_lrck_period"}, 64'(fs_q[i] - fs_q[i-1]), 64'(FRAME_CLK));
        fs_q.delete();
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int base_rdy, base_ur;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        step(3);
        check_eq("rst_bck",   64'(bck),            64'd0);
        check_eq("rst_lrck",  64'(lrck),           64'd1);
        check_eq("rst_sdata", 64'(sdata),          64'd0);
        check_eq("rst_ready", 64'(s_ready),        64'd0);
        check_eq("rst_run",   64'(running),        64'd0);
        check_eq("rst_count", 64'(underrun_count), 64'd0);
        reset_n = 1'b1;
        step(2);

        // Single fixed sample, enable dropped at bit 10: frame completes, then stop.
        use_fixed = 1'b1;
        src_on    = 1'b1;
        base_rdy  = rdy_cnt;
        fs_q.delete();
        enable = 1'b1;
        step(1);
        check_eq("start_lrck",  64'(lrck),        64'd0);
        check_eq("start_run",   64'(running),     64'd1);
        check_eq("start_ready", 64'(s_ready),     64'd1);
        check_eq("start_fs",    64'(frame_start), 64'd1);
        check_eq("start_bck",   64'(bck),         64'd0);
        step(41);
        enable = 1'b0;
        step(214);
        check_eq("drain_run",   64'(running), 64'd1);
        step(1);
        check_eq("stop_run",    64'(running), 64'd0);
        check_eq("stop_lrck",   64'(lrck),    64'd1);
        check_eq("stop_bck",    64'(bck),     64'd0);
        step(4);
        check_eq("t2_ready_cnt", 64'(rdy_cnt - base_rdy), 64'd1);
        check_eq("t2_frames", 64'(rx_q.size()), 64'd1);
        if (rx_q.size() > 0) check_eq("t2_sample", 64'(rx_q[0]), 64'h0000_ABCDEF_123456);
        rx_q.delete();
        exp_q.delete();
        use_fixed = 1'b0;

        // Four random frames with s_valid held high.
        base_rdy = rdy_cnt;
        base_ur  = ur_cnt;
        fs_q.delete();
        enable = 1'b1;
        step(809);
        enable = 1'b0;
        step(216);
        check_eq("t3_stop_run", 64'(running), 64'd0);
        step(4);
        check_eq("t3_ready_cnt", 64'(rdy_cnt - base_rdy), 64'd4);
        check_eq("t3_underruns", 64'(ur_cnt - base_ur),   64'd0);
        check_eq("t3_count",     64'(underrun_count),     64'(exp_underruns));
        compare_frames("t3");
        check_periods("t3");

        // Third frame finds s_valid low.
        base_rdy = rdy_cnt;
        base_ur  = ur_cnt;
        gap_hs   = hs_cnt + 2;
        fs_q.delete();
        enable = 1'b1;
        step(809);
        enable = 1'b0;
        step(216);
        step(4);
        gap_hs = -1;
        check_eq("t4_ready_cnt", 64'(rdy_cnt - base_rdy), 64'd4);
        check_eq("t4_underruns", 64'(ur_cnt - base_ur),   64'd1);
        check_eq("t4_count",     64'(underrun_count),     64'(exp_underruns));
        compare_frames("t4");
        check_periods("t4");

        // Drop enable at bit 10, re-raise at bit 40: next frame follows without a gap.
        base_rdy = rdy_cnt;
        fs_q.delete();
        enable = 1'b1;
        step(42);
        enable = 1'b0;
        step(120);
        check_eq("t6_drain_run", 64'(running), 64'd1);
        enable = 1'b1;
        step(95);
        check_eq("t6_fs",    64'(frame_start), 64'd1);
        check_eq("t6_ready", 64'(s_ready),     64'd1);
        check_eq("t6_run",   64'(running),     64'd1);
        step(41);
        enable = 1'b0;
        step(215);
        check_eq("t6_stop_run", 64'(running), 64'd0);
        step(4);
        check_eq("t6_ready_cnt", 64'(rdy_cnt - base_rdy), 64'd2);
        compare_frames("t6");
        check_periods("t6");
        check_eq("pad_bits", 64'(pad_errs), 64'd0);

        // Asynchronous reset in the middle of a running frame.
        enable = 1'b1;
        step(300);
        for (int i = 0; i < 64 && !(bck && !lrck); i++) step(1);
        check_eq("pre_reset_state", 64'({bck, lrck, running}), 64'b101);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_bck",   64'(bck),            64'd0);
        check_eq("arst_lrck",  64'(lrck),           64'd1);
        check_eq("arst_sdata", 64'(sdata),          64'd0);
        check_eq("arst_ready", 64'(s_ready),        64'd0);
        check_eq("arst_run",   64'(running),        64'd0);
        check_eq("arst_count", 64'(underrun_count), 64'd0);
        enable = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
